// File: rtl/ntt_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ntt_fifo_ctrl_pkg
// Shared definitions for the NTT FIFO controller slice:
//   - operation mode encodings (identical to the values the reordering FIFO
//     decodes, so the latched mode can be forwarded untouched)
//   - controller FSM state encodings
//   - default geometry of one polynomial pass through the datapath
//   - small mode classification helpers
// ---------------------------------------------------------------------------
package ntt_fifo_ctrl_pkg;

  // Width of the mode field shared by the controller and the FIFO.
  localparam int MODE_W = 3;

  // Default polynomial geometry: 256 coefficients packed 4 per 96-bit word.
  localparam int NUM_WORDS_DEF  = 64;
  localparam int NUM_PASSES_DEF = 4;
  localparam int PIPE_LAT_DEF   = 11;
  localparam int ADDR_W_DEF     = $clog2(NUM_WORDS_DEF);

  // Operation modes as seen by the butterfly datapath and the FIFO.
  typedef enum logic [MODE_W-1:0] {
    FORWARD_NTT_MODE = 3'd0,
    INVERSE_NTT_MODE = 3'd1,
    MULT_MODE        = 3'd2,
    ADD_MODE         = 3'd3,
    SUB_MODE         = 3'd4
  } mode_e;

  // Controller FSM states. Kept as plain constants so the encoding stays
  // stable for older tooling and for anyone probing the state register.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  // Forward and inverse NTT are the only multi-pass operations and the only
  // ones that need the FIFO reordering network to advance.
  function automatic logic is_ntt_mode(input logic [MODE_W-1:0] m);
    return (m == FORWARD_NTT_MODE) || (m == INVERSE_NTT_MODE);
  endfunction

  // Encodings above SUB_MODE are reserved; such a request completes at once
  // without touching the RAM.
  function automatic logic is_known_mode(input logic [MODE_W-1:0] m);
    return (m <= SUB_MODE);
  endfunction

endpackage

// File: rtl/ntt_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ntt_fifo_ctrl_if
// Bundles the request handshake from the top-level Dilithium controller and
// the strobes/addresses driven into the polynomial RAM and reordering FIFO.
//   master : requester side  (drives start, mode, hold)
//   slave  : ntt_fifo_ctrl   (drives busy, done, RAM and FIFO controls)
// Signals:
//   start     single-cycle operation request
//   mode      requested operation (mode_e encoding)
//   hold      datapath stall
//   busy      operation in progress
//   done      one-cycle completion pulse
//   rd_en     RAM read strobe,  rd_addr RAM read word address
//   wr_en     RAM write strobe, wr_addr RAM write word address
//   bank_sel  read bank select (write bank is the complement)
//   fifo_en   FIFO advance enable
//   fifo_rst  FIFO phase-counter reset
//   fifo_mode latched operation mode forwarded to the FIFO
// ---------------------------------------------------------------------------
interface ntt_fifo_ctrl_if
  import ntt_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic [MODE_W-1:0] mode;
  logic              hold;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              bank_sel;
  logic              fifo_en;
  logic              fifo_rst;
  logic [MODE_W-1:0] fifo_mode;

  modport master (
    output start, mode, hold,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr,
           bank_sel, fifo_en, fifo_rst, fifo_mode
  );

  modport slave (
    input  start, mode, hold,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr,
           bank_sel, fifo_en, fifo_rst, fifo_mode
  );

endinterface

// File: rtl/ntt_fifo_ctrl_valid_pipe.sv
// ---------------------------------------------------------------------------
// ntt_valid_pipe
// Valid-bit shift register that tracks transactions travelling through a
// fixed-latency datapath. A bit entered at valid_i appears at valid_o exactly
// DEPTH advancing cycles later. While hold_i is high the whole register is
// frozen, mirroring a stalled datapath.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset, clears every stage
//   hold_i    freeze the pipe
//   valid_i   transaction entering the datapath this cycle
//   valid_o   transaction leaving the datapath this cycle (tail stage)
//   pending_o some transaction is still in flight behind the tail stage
// ---------------------------------------------------------------------------
module ntt_valid_pipe #(
  parameter int DEPTH = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic valid_i,
  output logic valid_o,
  output logic pending_o
);

  localparam logic [DEPTH-1:0] TAIL_MASK = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Advance by one stage on every non-held cycle. Writing the shift as a
  // left shift plus OR keeps the expression legal for a depth of one.
  always_comb begin
    pipe_d = pipe_q;
    if (!hold_i) begin
      pipe_d = (pipe_q << 1) | DEPTH'(valid_i);
    end
  end

  // State register; reset empties the pipe so an aborted operation leaves
  // no phantom writes behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // The tail stage is the one being retired now; anything else still set is
  // a transaction that has not reached the write port yet.
  assign valid_o   = pipe_q[DEPTH-1];
  assign pending_o = |(pipe_q & ~TAIL_MASK);

endmodule

// File: rtl/ntt_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_fifo_ctrl
// Sequences one polynomial operation through the NTT butterfly datapath and
// its 96-bit reordering FIFO. Each pass clears the FIFO phase, streams every
// RAM word into the datapath, then drains the datapath until the last result
// has been written back. NTT/INTT run NUM_PASSES passes, ping-ponging the
// RAM banks between passes; MULT/ADD/SUB run a single pass with the FIFO
// parked. Reserved modes complete immediately.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, aborts any operation without done
//   bus   ntt_fifo_ctrl_if.slave: start/mode/hold in; busy, done, RAM
//         read/write strobes and addresses, bank_sel, FIFO controls out
// ---------------------------------------------------------------------------
module ntt_fifo_ctrl
  import ntt_fifo_ctrl_pkg::*;
#(
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int NUM_PASSES = NUM_PASSES_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF,
  parameter int ADDR_W     = $clog2(NUM_WORDS)
) (
  input logic            clk,
  input logic            rst,
  ntt_fifo_ctrl_if.slave bus
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic [PASS_W-1:0] pass_q;
  logic [PASS_W-1:0] pass_d;
  logic              bank_q;
  logic              bank_d;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [ADDR_W-1:0] rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] wr_cnt_d;

  logic rd_en;
  logic wr_en;
  logic pipe_valid;
  logic pipe_pending;
  logic ntt_op;
  logic last_rd;
  logic last_wr;
  logic more_passes;
  logic in_datapath;

  // Track reads through the butterfly + FIFO latency so each write fires
  // exactly PIPE_LAT advancing cycles after its read.
  ntt_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (bus.hold),
    .valid_i   (rd_en),
    .valid_o   (pipe_valid),
    .pending_o (pipe_pending)
  );

  // Strobe and condition decode. Hold gates every strobe so a stalled cycle
  // neither touches the RAM nor advances the FIFO. A pass is finished when
  // the final word is being written and nothing else is in flight.
  always_comb begin
    ntt_op      = is_ntt_mode(mode_q);
    in_datapath = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    rd_en       = (state_q == ST_STREAM) && !bus.hold;
    wr_en       = pipe_valid && !bus.hold;
    last_rd     = rd_en && (rd_cnt_q == LAST_ADDR);
    last_wr     = wr_en && (wr_cnt_q == LAST_ADDR) && !pipe_pending;
    more_passes = ntt_op && (pass_q != LAST_PASS);
  end

  // Next-state logic. Address counters step on their own strobes and are
  // rewound in CLR so every pass walks the full word range from zero. CLR
  // always lasts one cycle, even under hold, because the FIFO reset must not
  // be stretched. FIN waits out a hold so done is never lost.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pass_d   = pass_q;
    bank_d   = bank_q;
    rd_cnt_d = rd_en ? (rd_cnt_q + ADDR_W'(1)) : rd_cnt_q;
    wr_cnt_d = wr_en ? (wr_cnt_q + ADDR_W'(1)) : wr_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          pass_d  = '0;
          bank_d  = 1'b0;
          state_d = is_known_mode(bus.mode) ? ST_CLR : ST_FIN;
        end
      end

      ST_CLR: begin
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        state_d  = ST_STREAM;
      end

      ST_STREAM: begin
        if (last_rd) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (last_wr) begin
          if (more_passes) begin
            pass_d  = pass_q + PASS_W'(1);
            bank_d  = ~bank_q;
            state_d = ST_CLR;
          end else begin
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        if (!bus.hold) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers. Reset wins over a coincident start and leaves every
  // output at zero with the FSM parked in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      pass_q   <= '0;
      bank_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pass_q   <= pass_d;
      bank_q   <= bank_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Output drive. The FIFO only advances for NTT/INTT; element-wise modes
  // bypass its reordering, so its phase is left untouched.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FIN) && !bus.hold;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_cnt_q;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_cnt_q;
  assign bus.bank_sel  = bank_q;
  assign bus.fifo_en   = in_datapath && ntt_op && !bus.hold;
  assign bus.fifo_rst  = (state_q == ST_CLR);
  assign bus.fifo_mode = mode_q;

endmodule

// File: tb/tb_ntt_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ntt_fifo_ctrl
// Scoreboard bench for ntt_fifo_ctrl. Each operation pushes its expected RAM
// reads, RAM writes, FIFO resets and completion into queues. Expected times
// are counted in "effective cycles": the start cycle is 0 and every cycle
// without hold advances the count by one. A pass occupies 1 + NW + LAT
// effective cycles (CLR, streaming reads, drain), reads of pass p sit at
// 2 + PERIOD*p + k, writes LAT later, and done follows the last pass.
// Latency is reported inclusively, from the start cycle to the done cycle.
// A negedge monitor pops and compares whenever the DUT strobes something.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ntt_fifo_ctrl;
  import ntt_fifo_ctrl_pkg::*;

  localparam int NW     = 64;
  localparam int NP     = 4;
  localparam int LAT    = 11;
  localparam int AW     = 6;
  localparam int PERIOD = 1 + NW + LAT;

  typedef struct {
    int addr;
    int bank;
    int eTime;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  ntt_fifo_ctrl_if #(.ADDR_W(AW)) bus ();

  ntt_fifo_ctrl #(
    .NUM_WORDS  (NW),
    .NUM_PASSES (NP),
    .PIPE_LAT   (LAT),
    .ADDR_W     (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ev_t rdQ[$];
  ev_t wrQ[$];
  int  rstQ[$];
  int  doneQ[$];

  int errors = 0;
  int checks = 0;

  bit         opActive = 1'b0;
  int         curE;
  int         nextE;
  int         realCyc;
  int         fifoEnCnt;
  int         holdCnt;
  int         expFifoEn;
  int         expLatency;
  int         curPasses;
  logic [2:0] expMode;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference schedule for one operation, built from the pass structure.
  task automatic applyStimulus(input logic [2:0] m, input int expLat);
    bit ntt;
    ntt        = (m == 3'd0) || (m == 3'd1);
    expMode    = m;
    expLatency = expLat;
    if (m > 3'd4) begin
      curPasses = 0;
      expFifoEn = 0;
      doneQ.push_back(1);
    end else begin
      curPasses = ntt ? NP : 1;
      expFifoEn = ntt ? curPasses * (NW + LAT) : 0;
      for (int p = 0; p < curPasses; p++) begin
        rstQ.push_back(1 + PERIOD * p);
        for (int k = 0; k < NW; k++) begin
          rdQ.push_back('{addr: k, bank: p % 2, eTime: 2 + PERIOD * p + k});
          wrQ.push_back('{addr: k, bank: p % 2, eTime: 2 + PERIOD * p + k + LAT});
        end
      end
      doneQ.push_back(1 + PERIOD * curPasses);
    end
    bus.mode  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = 3'($urandom_range(0, 7));
  endtask

  // Hold is only placed where the DUT is streaming or draining.
  function automatic bit holdAllowed(input int e);
    int off;
    off = e - 1;
    if (off < 0) return 1'b0;
    return ((off / PERIOD) < curPasses) && ((off % PERIOD) >= 1);
  endfunction

  // Compare one non-held active cycle against the queued expectations.
  task automatic scoreCycle();
    ev_t ev;
    int  doneE;
    int  wantLat;
    checkOutput("busyActive", int'(bus.busy), 1);
    if (bus.fifo_rst) begin
      if (rstQ.size() == 0) checkOutput("fifoRstUnexpected", curE, -1);
      else checkOutput("fifoRstTime", curE, rstQ.pop_front());
    end
    if (bus.rd_en) begin
      if (rdQ.size() == 0) checkOutput("rdUnexpected", int'(bus.rd_addr), -1);
      else begin
        ev = rdQ.pop_front();
        checkOutput("rdAddr", int'(bus.rd_addr), ev.addr);
        checkOutput("rdBank", int'(bus.bank_sel), ev.bank);
        checkOutput("rdTime", curE, ev.eTime);
      end
    end
    if (bus.wr_en) begin
      if (wrQ.size() == 0) checkOutput("wrUnexpected", int'(bus.wr_addr), -1);
      else begin
        ev = wrQ.pop_front();
        checkOutput("wrAddr", int'(bus.wr_addr), ev.addr);
        checkOutput("wrBank", int'(bus.bank_sel), ev.bank);
        checkOutput("wrTime", curE, ev.eTime);
      end
    end
    if (bus.fifo_en) fifoEnCnt++;
    if (bus.done) begin
      if (doneQ.size() == 0) checkOutput("doneUnexpected", curE, -1);
      else begin
        doneE   = doneQ.pop_front();
        wantLat = (expLatency < 0) ? (doneE + 1 + holdCnt) : expLatency;
        checkOutput("doneTime", curE, doneE);
        checkOutput("latency", realCyc + 1, wantLat);
        checkOutput("fifoEnCount", fifoEnCnt, expFifoEn);
        checkOutput("fifoMode", int'(bus.fifo_mode), int'(expMode));
        checkOutput("leftoverEvents", rdQ.size() + wrQ.size() + rstQ.size(), 0);
      end
      opActive = 1'b0;
    end
  endtask

  // Monitor: samples mid-cycle, tracks effective time and scores strobes.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      opActive = 1'b0;
      rdQ.delete();
      wrQ.delete();
      rstQ.delete();
      doneQ.delete();
    end else if (!opActive) begin
      checkOutput("idleStrobes",
                  int'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.fifo_en, bus.fifo_rst}), 0);
      if (bus.start) begin
        opActive  = 1'b1;
        curE      = 0;
        nextE     = 1;
        realCyc   = 0;
        fifoEnCnt = 0;
        holdCnt   = 0;
      end
    end else begin
      curE = nextE;
      realCyc++;
      if (bus.hold) begin
        holdCnt++;
        checkOutput("heldStrobes", int'({bus.rd_en, bus.wr_en, bus.fifo_en, bus.done}), 0);
        checkOutput("busyHeld", int'(bus.busy), 1);
      end else begin
        nextE = curE + 1;
        scoreCycle();
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for n cycles, then confirm every output reads zero.
  task automatic doReset(input int n);
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstDone", int'(bus.done), 0);
    checkOutput("rstRdEn", int'(bus.rd_en), 0);
    checkOutput("rstWrEn", int'(bus.wr_en), 0);
    checkOutput("rstFifoEn", int'(bus.fifo_en), 0);
    checkOutput("rstFifoRst", int'(bus.fifo_rst), 0);
    checkOutput("rstBankSel", int'(bus.bank_sel), 0);
    checkOutput("rstRdAddr", int'(bus.rd_addr), 0);
    checkOutput("rstWrAddr", int'(bus.wr_addr), 0);
    checkOutput("rstFifoMode", int'(bus.fifo_mode), 0);
    @(posedge clk);
    #1;
  endtask

  // plan 0: no hold; 1: directed holds; 2: random holds; 3: start while busy.
  // abortAt >= 0 resets the DUT when that effective cycle is reached.
  task automatic runOp(input logic [2:0] m, input int plan, input int expLat, input int abortAt);
    int  h3;
    int  h5;
    bit  hld;
    bit  aborted;
    h3      = 0;
    h5      = 0;
    aborted = 1'b0;
    applyStimulus(m, expLat);
    for (int budget = 0; budget < 3000 && opActive; budget++) begin
      if (abortAt >= 0 && nextE == abortAt) begin
        aborted = 1'b1;
        break;
      end
      hld = 1'b0;
      if (plan == 1) begin
        if (nextE == 22 && h3 < 3) begin
          hld = 1'b1;
          h3++;
        end else if (nextE == 146 && h5 < 5) begin
          hld = 1'b1;
          h5++;
        end
      end else if (plan == 2) begin
        hld = holdAllowed(nextE) && ($urandom_range(0, 7) == 0);
      end
      bus.start = (plan == 3) && (nextE == 100);
      if (bus.start) bus.mode = 3'($urandom_range(0, 7));
      bus.hold = hld;
      @(posedge clk);
      #1;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    if (aborted) begin
      doReset(1);
      idleCycles(5);
    end else begin
      checkOutput("opCompleted", int'(opActive), 0);
      if (opActive) doReset(2);
      idleCycles(2);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 3'd0;
    bus.hold  = 1'b0;
    doReset(3);

    $display("[TB] forward NTT, start pulsed again while busy");
    runOp(3'(FORWARD_NTT_MODE), 3, 306, -1);

    $display("[TB] ADD single pass");
    runOp(3'(ADD_MODE), 0, 78, -1);

    $display("[TB] forward NTT with directed holds");
    runOp(3'(FORWARD_NTT_MODE), 1, 314, -1);

    $display("[TB] reset during pass 2 streaming, then fresh run");
    runOp(3'(FORWARD_NTT_MODE), 0, -1, 1 + 2 * PERIOD + 30);
    runOp(3'(FORWARD_NTT_MODE), 0, 306, -1);

    $display("[TB] reserved mode 6");
    runOp(3'd6, 0, 2, -1);

    $display("[TB] start coincident with reset");
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 3'(FORWARD_NTT_MODE);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    idleCycles(4);
    checkOutput("busyAfterRstStart", int'(bus.busy), 0);

    $display("[TB] randomized operations with random holds");
    for (int i = 0; i < 4; i++) begin
      runOp(3'($urandom_range(0, 7)), 2, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
